vga_sxga_timing: RTL and testbench

Video timing generator for 1280x1024@60 Hz (SXGA) on the 108 MHz pixel clock from the VGA PLL. It consumes the PLL `locked` indication and holds all video outputs idle until lock has been stable for a programmable number of cycles. It then produces hsync, vsync, display-enable and pixel coordinates for the downstream pixel pipeline and DAC/VGA pins. Loss of lock returns it to the idle/wait state.

---
 rtl/vga_sxga_timing_if.sv | 18 +
 rtl/vga_sxga_timing.sv | 162 ++++++++++++++++
 tb/tb_vga_sxga_timing.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sxga_timing_if.sv
// rtl/vga_sxga_timing_if.sv - video timing bundle from the SXGA timing generator to the pixel pipeline
interface vga_sxga_timing_if;
   logic        hsync;
   logic        vsync;
   logic        de;
   logic [10:0] x;
   logic [10:0] y;
   logic        frame_start;
   logic        running;

   modport master (
      output hsync, vsync, de, x, y, frame_start, running
   );

   modport slave (
      input hsync, vsync, de, x, y, frame_start, running
   );
endinterface

// File: rtl/vga_sxga_timing.sv
// rtl/vga_sxga_timing.sv - 1280x1024@60 timing generator gated by PLL lock
// Optional macro VGA_SYNC_NEG_EN makes hsync/vsync active-low.
module vga_sxga_timing #(
   parameter int H_ACTIVE    = 1280,
   parameter int H_FP        = 48,
   parameter int H_SYNC      = 112,
   parameter int H_BP        = 248,
   parameter int V_ACTIVE    = 1024,
   parameter int V_FP        = 1,
   parameter int V_SYNC      = 3,
   parameter int V_BP        = 38,
   parameter int LOCK_STABLE = 1024
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              locked,
   vga_sxga_timing_if.master vid
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int LOCK_W  = $clog2(LOCK_STABLE) + 1;

   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
   localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_STABLE - 1);

`ifdef VGA_SYNC_NEG_EN
   localparam logic SYNC_ON = 1'b0;
`else
   localparam logic SYNC_ON = 1'b1;
`endif
   localparam logic SYNC_OFF = ~SYNC_ON;

   typedef enum logic [0:0] {
      S_WAIT_LOCK = 1'b0,
      S_RUN       = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [LOCK_W-1:0] r_lock_cnt;
   logic [LOCK_W-1:0] w_lock_cnt_nxt;
   logic [10:0]       r_h_cnt;
   logic [10:0]       w_h_cnt_nxt;
   logic [10:0]       r_v_cnt;
   logic [10:0]       w_v_cnt_nxt;

   logic              r_hsync;
   logic              r_vsync;
   logic              r_de;
   logic [10:0]       r_x;
   logic [10:0]       r_y;
   logic              r_frame_start;
   logic              r_running;

   logic              w_de;
   logic              w_hs_act;
   logic              w_vs_act;
   logic              w_frame_start;

   always_comb begin
      w_state_nxt    = r_state;
      w_lock_cnt_nxt = r_lock_cnt;
      w_h_cnt_nxt    = r_h_cnt;
      w_v_cnt_nxt    = r_v_cnt;
      case (r_state)
         S_WAIT_LOCK: begin
            w_h_cnt_nxt = 11'd0;
            w_v_cnt_nxt = 11'd0;
            if (!locked) begin
               w_lock_cnt_nxt = '0;
            end else if (r_lock_cnt == LOCK_LAST) begin
               w_state_nxt    = S_RUN;
               w_lock_cnt_nxt = '0;
            end else begin
               w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1);
            end
         end
         S_RUN: begin
            if (!locked) begin
               w_state_nxt    = S_WAIT_LOCK;
               w_lock_cnt_nxt = '0;
               w_h_cnt_nxt    = 11'd0;
               w_v_cnt_nxt    = 11'd0;
            end else if (r_h_cnt == H_LAST) begin
               w_h_cnt_nxt = 11'd0;
               w_v_cnt_nxt = (r_v_cnt == V_LAST) ? 11'd0 : r_v_cnt + 11'd1;
            end else begin
               w_h_cnt_nxt = r_h_cnt + 11'd1;
            end
         end
         default: begin
            w_state_nxt    = S_WAIT_LOCK;
            w_lock_cnt_nxt = '0;
            w_h_cnt_nxt    = 11'd0;
            w_v_cnt_nxt    = 11'd0;
         end
      endcase
   end

   // vsync spans whole lines, so it decodes from v_cnt alone
   always_comb begin
      w_de          = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
      w_hs_act      = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
      w_vs_act      = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
      w_frame_start = (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state       <= S_WAIT_LOCK;
         r_lock_cnt    <= '0;
         r_h_cnt       <= 11'd0;
         r_v_cnt       <= 11'd0;
         r_hsync       <= SYNC_OFF;
         r_vsync       <= SYNC_OFF;
         r_de          <= 1'b0;
         r_x           <= 11'd0;
         r_y           <= 11'd0;
         r_frame_start <= 1'b0;
         r_running     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
         r_h_cnt    <= w_h_cnt_nxt;
         r_v_cnt    <= w_v_cnt_nxt;
         r_running  <= (w_state_nxt == S_RUN);
         // outputs trail the counters by one cycle and idle whenever not running
         if (r_state == S_RUN) begin
            r_hsync       <= w_hs_act ? SYNC_ON : SYNC_OFF;
            r_vsync       <= w_vs_act ? SYNC_ON : SYNC_OFF;
            r_de          <= w_de;
            r_x           <= w_de ? r_h_cnt : 11'd0;
            r_y           <= w_de ? r_v_cnt : 11'd0;
            r_frame_start <= w_frame_start;
         end else begin
            r_hsync       <= SYNC_OFF;
            r_vsync       <= SYNC_OFF;
            r_de          <= 1'b0;
            r_x           <= 11'd0;
            r_y           <= 11'd0;
            r_frame_start <= 1'b0;
         end
      end
   end

   assign vid.hsync       = r_hsync;
   assign vid.vsync       = r_vsync;
   assign vid.de          = r_de;
   assign vid.x           = r_x;
   assign vid.y           = r_y;
   assign vid.frame_start = r_frame_start;
   assign vid.running     = r_running;

endmodule

// File: tb/tb_vga_sxga_timing.sv
// tb/tb_vga_sxga_timing.sv - directed bench for vga_sxga_timing on a scaled-down raster
module tb_vga_sxga_timing;

   localparam int H_ACTIVE = 20;
   localparam int H_FP     = 4;
   localparam int H_SYNC   = 6;
   localparam int H_BP     = 8;
   localparam int V_ACTIVE = 10;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 3;
   localparam int V_BP     = 4;
   localparam int LOCK_STABLE = 16;
   localparam int H_TOTAL = 38;
   localparam int V_TOTAL = 18;
   localparam int FRAME   = 684;

`ifdef VGA_SYNC_NEG_EN
   localparam logic SYNC_ACT = 1'b0;
`else
   localparam logic SYNC_ACT = 1'b1;
`endif
   localparam logic SYNC_IDLE = ~SYNC_ACT;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic locked = 1'b0;
   int   checks = 0;
   int   errors = 0;

   vga_sxga_timing_if vif ();

   vga_sxga_timing #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .LOCK_STABLE(LOCK_STABLE)
   ) dut (
      .refclk(clk),
      .rst(rst),
      .locked(locked),
      .vid(vif)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      locked = 1'b1;
      repeat (3) tick();
      checks++;
      if ({vif.hsync, vif.vsync} !== {SYNC_IDLE, SYNC_IDLE}) begin
         errors++;
         $display("FAIL reset_sync: got %b%b expected %b%b", vif.hsync, vif.vsync, SYNC_IDLE, SYNC_IDLE);
      end
      checks++;
      if ({vif.de, vif.frame_start, vif.running} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got de/fs/run=%b%b%b expected 000", vif.de, vif.frame_start, vif.running);
      end
      checks++;
      if ({vif.x, vif.y} !== 22'd0) begin
         errors++;
         $display("FAIL reset_xy: got x=%0d y=%0d expected 0 0", vif.x, vif.y);
      end
   endtask

   task automatic test_startup();
      int n;
      rst = 1'b0;
      locked = 1'b1;
      n = 0;
      while (vif.running !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != LOCK_STABLE) begin
         errors++;
         $display("FAIL startup_latency: got %0d expected %0d", n, LOCK_STABLE);
      end
      tick();
      checks++;
      if ({vif.frame_start, vif.de, vif.x, vif.y} !== {1'b1, 1'b1, 22'd0}) begin
         errors++;
         $display("FAIL startup_first_pixel: got fs=%b de=%b x=%0d y=%0d expected 1 1 0 0",
                  vif.frame_start, vif.de, vif.x, vif.y);
      end
      tick();
      checks++;
      if ({vif.frame_start, vif.de, vif.x} !== {1'b0, 1'b1, 11'd1}) begin
         errors++;
         $display("FAIL startup_second_pixel: got fs=%b de=%b x=%0d expected 0 1 1",
                  vif.frame_start, vif.de, vif.x);
      end
   endtask

   task automatic test_lock_glitch();
      int n;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      locked = 1'b1;
      repeat (9) tick();
      locked = 1'b0;
      tick();
      locked = 1'b1;
      checks++;
      if (vif.running !== 1'b0) begin
         errors++;
         $display("FAIL glitch_running_early: got %b expected 0", vif.running);
      end
      n = 0;
      while (vif.running !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != LOCK_STABLE) begin
         errors++;
         $display("FAIL glitch_relock_latency: got %0d expected %0d", n, LOCK_STABLE);
      end
   endtask

   // entered with running just risen; sample k reflects counter cycle k-1
   task automatic test_full_frame();
      int de_cnt, hs_cnt, vs_cnt, first_hs, first_vs, fs_first, fs_second;
      int max_x, max_y, idle_bad, run_drop;
      de_cnt = 0; hs_cnt = 0; vs_cnt = 0; first_hs = -1; first_vs = -1;
      fs_first = -1; fs_second = -1; max_x = 0; max_y = 0; idle_bad = 0; run_drop = 0;
      for (int k = 1; k <= FRAME + 2; k++) begin
         tick();
         if (vif.running !== 1'b1) run_drop++;
         if (vif.frame_start === 1'b1) begin
            if (fs_first < 0) fs_first = k;
            else if (fs_second < 0) fs_second = k;
         end
         if (k <= FRAME) begin
            if (vif.de === 1'b1) begin
               de_cnt++;
               if (int'(vif.x) > max_x) max_x = int'(vif.x);
               if (int'(vif.y) > max_y) max_y = int'(vif.y);
            end else if (vif.x !== 11'd0 || vif.y !== 11'd0) begin
               idle_bad++;
            end
            if (vif.hsync === SYNC_ACT) begin
               hs_cnt++;
               if (first_hs < 0) first_hs = k;
            end
            if (vif.vsync === SYNC_ACT) begin
               vs_cnt++;
               if (first_vs < 0) first_vs = k;
            end
         end
      end
      checks++;
      if (fs_first != 1) begin errors++; $display("FAIL frame_first_fs: got %0d expected 1", fs_first); end
      checks++;
      if (fs_second != FRAME + 1) begin errors++; $display("FAIL frame_period: got %0d expected %0d", fs_second, FRAME + 1); end
      checks++;
      if (de_cnt != H_ACTIVE * V_ACTIVE) begin errors++; $display("FAIL frame_de_count: got %0d expected %0d", de_cnt, H_ACTIVE * V_ACTIVE); end
      checks++;
      if (hs_cnt != H_SYNC * V_TOTAL) begin errors++; $display("FAIL frame_hs_count: got %0d expected %0d", hs_cnt, H_SYNC * V_TOTAL); end
      checks++;
      if (vs_cnt != V_SYNC * H_TOTAL) begin errors++; $display("FAIL frame_vs_count: got %0d expected %0d", vs_cnt, V_SYNC * H_TOTAL); end
      checks++;
      if (first_hs != 25) begin errors++; $display("FAIL frame_hs_start: got %0d expected 25", first_hs); end
      checks++;
      if (first_vs != 419) begin errors++; $display("FAIL frame_vs_start: got %0d expected 419", first_vs); end
      checks++;
      if (max_x != 19) begin errors++; $display("FAIL frame_max_x: got %0d expected 19", max_x); end
      checks++;
      if (max_y != 9) begin errors++; $display("FAIL frame_max_y: got %0d expected 9", max_y); end
      checks++;
      if (idle_bad != 0) begin errors++; $display("FAIL frame_blank_xy: got %0d nonzero blank samples expected 0", idle_bad); end
      checks++;
      if (run_drop != 0) begin errors++; $display("FAIL frame_running: got %0d low samples expected 0", run_drop); end
   endtask

   task automatic test_lock_loss();
      int n;
      bit found;
      found = 1'b0;
      n = 0;
      while (!found && n < 2000) begin
         tick();
         n++;
         if (vif.de === 1'b1 && vif.y === 11'd5 && vif.x === 11'd7) found = 1'b1;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL loss_find_pixel: got timeout expected pixel (7,5)"); end
      locked = 1'b0;
      tick();
      checks++;
      if (vif.running !== 1'b0) begin errors++; $display("FAIL loss_running: got %b expected 0", vif.running); end
      tick();
      checks++;
      if ({vif.hsync, vif.vsync, vif.de, vif.frame_start, vif.x, vif.y} !== {SYNC_IDLE, SYNC_IDLE, 2'b00, 22'd0}) begin
         errors++;
         $display("FAIL loss_idle: got hs=%b vs=%b de=%b fs=%b x=%0d y=%0d expected idle",
                  vif.hsync, vif.vsync, vif.de, vif.frame_start, vif.x, vif.y);
      end
      tick();
      locked = 1'b1;
      n = 0;
      while (vif.running !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      tick();
      checks++;
      if (n != LOCK_STABLE || {vif.frame_start, vif.de, vif.x, vif.y} !== {2'b11, 22'd0}) begin
         errors++;
         $display("FAIL loss_restart: got latency=%0d fs=%b de=%b x=%0d y=%0d expected %0d 1 1 0 0",
                  n, vif.frame_start, vif.de, vif.x, vif.y, LOCK_STABLE);
      end
   endtask

   task automatic test_reset_mid_vsync();
      int n;
      n = 0;
      while (vif.vsync !== SYNC_ACT && n < 2000) begin
         tick();
         n++;
      end
      checks++;
      if (vif.vsync !== SYNC_ACT) begin errors++; $display("FAIL rst_find_vsync: got %b expected %b", vif.vsync, SYNC_ACT); end
      rst = 1'b1;
      tick();
      checks++;
      if ({vif.hsync, vif.vsync, vif.de, vif.running, vif.frame_start} !== {SYNC_IDLE, SYNC_IDLE, 3'b000}) begin
         errors++;
         $display("FAIL rst_idle: got hs=%b vs=%b de=%b run=%b fs=%b expected %b %b 0 0 0",
                  vif.hsync, vif.vsync, vif.de, vif.running, vif.frame_start, SYNC_IDLE, SYNC_IDLE);
      end
      tick();
      checks++;
      if ({vif.vsync, vif.de, vif.running} !== {SYNC_IDLE, 2'b00}) begin
         errors++;
         $display("FAIL rst_hold: got vs=%b de=%b run=%b expected %b 0 0", vif.vsync, vif.de, vif.running, SYNC_IDLE);
      end
      rst = 1'b0;
      n = 0;
      while (vif.running !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (n != LOCK_STABLE) begin errors++; $display("FAIL rst_relock_latency: got %0d expected %0d", n, LOCK_STABLE); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_lock_glitch();
      test_full_frame();
      test_lock_loss();
      test_reset_mid_vsync();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
